i2c_master_fsm: RTL and testbench

//  Single-byte I2C master sequencer: on a start pulse it issues START, a 7-bit address, the R/W bit
//  and an address-ACK phase, then writes one byte or reads one byte, then issues STOP.

---
 rtl/i2c_master_pkg.sv | 9 +
 rtl/i2c_master_fsm_if.sv | 31 +++
 rtl/i2c_scl_gen.sv | 33 +++
 rtl/i2c_master_fsm.sv | 123 ++++++++++++
 tb/tb_i2c_master_fsm.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: shared state encoding, bit-counter width and idle bus levels for the I2C master.
package i2c_master_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, RWBIT, ADDR_ACK, WRITE, DATA_ACK, READ, MACK, STOP
  } state_t;
  localparam int BIT_W = 3;
  localparam logic SDA_IDLE = 1'b1;
  localparam logic SCL_IDLE = 1'b1;
endpackage

// File: rtl/i2c_master_fsm_if.sv
// i2c_master_fsm_if: CPU-side request/response and pad signals of the I2C master.
// Optional nack flag appears when I2C_MASTER_NACK_FLAG_EN is defined.
interface i2c_master_fsm_if;
  logic       start;
  logic [6:0] address;
  logic       rw;
  logic [7:0] idata;
  logic       ack_addr;
  logic       sda_in;
  logic       hold;
  logic [7:0] odata;
  logic       i2c_sda;
  logic       i2c_scl;
`ifdef I2C_MASTER_NACK_FLAG_EN
  logic       nack;
`endif
  modport master (
    input  start, address, rw, idata, ack_addr, sda_in,
    output hold, odata, i2c_sda, i2c_scl
`ifdef I2C_MASTER_NACK_FLAG_EN
    , output nack
`endif
  );
  modport slave (
    output start, address, rw, idata, ack_addr, sda_in,
    input  hold, odata, i2c_sda, i2c_scl
`ifdef I2C_MASTER_NACK_FLAG_EN
    , input nack
`endif
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: SCL_HALF divider giving the SCL level plus rise/fall strobes for the edge about to happen.
module i2c_scl_gen
  import i2c_master_pkg::*;
#(
  parameter int SCL_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_park,
  output logic o_scl,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = SCL_HALF > 1 ? $clog2(SCL_HALF) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_scl;
  logic          w_tick;
  assign w_tick = i_en && r_cnt == CW'(SCL_HALF - 1);
  assign o_rise = w_tick && !r_scl;
  assign o_fall = w_tick && r_scl;
  assign o_scl  = r_scl;
  // i_park keeps SCL high through the final fall strobe so STOP can finish with SDA rising
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_scl <= SCL_IDLE;
    end else begin
      r_cnt <= (!i_en || w_tick) ? '0 : r_cnt + 1'b1;
      r_scl <= !i_en || (w_tick ? (!r_scl || i_park) : r_scl);
    end
  end
endmodule

// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: single-byte I2C master (START, addr+rw, ack wait, write or read byte, STOP).
// Define I2C_MASTER_NACK_FLAG_EN to get a sticky address-timeout nack output.
module i2c_master_fsm
  import i2c_master_pkg::*;
#(
  parameter int SCL_HALF     = 1,
  parameter int ACK_WAIT_MAX = 8
) (
  input logic               clk,
  input logic               reset,
  i2c_master_fsm_if.master  bus
);
  localparam int WW = $clog2(ACK_WAIT_MAX + 1);
  state_t           r_state;
  logic [BIT_W-1:0] r_bit;
  logic [WW-1:0]    r_wait;
  logic [7:0]       r_tx, r_data, r_shift, r_odata;
  logic             r_rw, r_sda, r_hold;
  logic             w_scl, w_rise, w_fall;
`ifdef I2C_MASTER_NACK_FLAG_EN
  logic r_nack;
  assign bus.nack = r_nack;
`endif
  assign bus.i2c_sda = r_sda;
  assign bus.i2c_scl = w_scl;
  assign bus.hold    = r_hold;
  assign bus.odata   = r_odata;
  i2c_scl_gen #(.SCL_HALF(SCL_HALF)) u_scl (
    .clk    (clk),
    .rst    (reset),
    .i_en   (r_state != IDLE),
    .i_park (r_state == STOP),
    .o_scl  (w_scl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );
  // Every slot begins on an SCL fall strobe: the state names the slot just finished
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sda   <= SDA_IDLE;
      r_hold  <= 1'b0;
      r_odata <= '0;
      r_tx    <= '0;
      r_data  <= '0;
      r_shift <= '0;
      r_rw    <= 1'b0;
      r_bit   <= '0;
      r_wait  <= '0;
`ifdef I2C_MASTER_NACK_FLAG_EN
      r_nack  <= 1'b0;
`endif
    end else begin
      if (r_state == READ && w_rise) r_shift <= {r_shift[6:0], bus.sda_in};
      if (r_state == IDLE) begin
        r_hold <= bus.start && !r_hold;
        if (bus.start && !r_hold) begin
          r_state <= START;
          r_sda   <= 1'b0;
          r_tx    <= {bus.address, bus.rw};
          r_rw    <= bus.rw;
          r_data  <= bus.idata;
`ifdef I2C_MASTER_NACK_FLAG_EN
          r_nack  <= 1'b0;
`endif
        end
      end else if (w_fall) begin
        case (r_state)
          START, ADDR: begin
            r_sda   <= r_tx[7];
            r_tx    <= {r_tx[6:0], 1'b0};
            r_bit   <= r_state == START ? BIT_W'(6) : r_bit - 1'b1;
            r_state <= (r_state == ADDR && r_bit == '0) ? RWBIT : ADDR;
          end
          RWBIT: begin
            r_sda   <= 1'b1;
            r_tx    <= r_data;
            r_wait  <= '0;
            r_state <= ADDR_ACK;
          end
          ADDR_ACK: begin
            if (bus.ack_addr) begin
              r_state <= r_rw ? READ : WRITE;
              r_sda   <= r_rw | r_tx[7];
              r_tx    <= {r_tx[6:0], 1'b0};
              r_bit   <= BIT_W'(7);
            end else if (r_wait == WW'(ACK_WAIT_MAX - 1)) begin
              r_state <= STOP;
              r_sda   <= 1'b0;
`ifdef I2C_MASTER_NACK_FLAG_EN
              r_nack  <= 1'b1;
`endif
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          WRITE: begin
            r_sda   <= r_bit == '0 ? 1'b1 : r_tx[7];
            r_tx    <= {r_tx[6:0], 1'b0};
            r_bit   <= r_bit - 1'b1;
            r_state <= r_bit == '0 ? DATA_ACK : WRITE;
          end
          READ: begin
            r_bit <= r_bit - 1'b1;
            if (r_bit == '0) begin
              r_state <= MACK;
              r_odata <= r_shift;
            end
          end
          DATA_ACK, MACK: begin
            r_state <= STOP;
            r_sda   <= 1'b0;
          end
          STOP: begin
            r_state <= IDLE;
            r_sda   <= SDA_IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb_i2c_master_fsm: random transfers checked cycle by cycle against a bus waveform built from slot rules.
module tb_i2c_master_fsm;
  localparam int H    = 3;
  localparam int MAXW = 8;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  i2c_master_fsm_if bus();
  i2c_master_fsm #(.SCL_HALF(H), .ACK_WAIT_MAX(MAXW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m_odata = 8'h00;
  logic       m_nack = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(logic scl, logic sda, int n);
    for (int i = 0; i < n; i++) exp_q.push_back({scl, sda, 1'b1});
  endtask

  // expected {scl, sda, hold} per clk from the first cycle after acceptance to hold dropping
  task automatic build(logic [6:0] a, logic rw, logic [7:0] wd, int ack_d);
    logic slots[$];
    int   n_ack;
    exp_q.delete();
    for (int i = 6; i >= 0; i--) slots.push_back(a[i]);
    slots.push_back(rw);
    n_ack = ack_d < MAXW ? ack_d + 1 : MAXW;
    for (int i = 0; i < n_ack; i++) slots.push_back(1'b1);
    if (ack_d < MAXW) begin
      for (int i = 7; i >= 0; i--) slots.push_back(rw ? 1'b1 : wd[i]);
      slots.push_back(1'b1);
    end
    push(1'b1, 1'b0, H);
    foreach (slots[i]) begin
      push(1'b0, slots[i], H);
      push(1'b1, slots[i], H);
    end
    push(1'b0, 1'b0, H);
    push(1'b1, 1'b0, H);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b110);
  endtask

  task automatic xfer(logic [6:0] a, logic rw, logic [7:0] wd, logic [7:0] rd, int ack_d, bit poke_en);
    int   r = 0;
    int   base = 9 + ack_d;
    int   poke;
    logic prev = 1'b1;
    build(a, rw, wd, ack_d);
    poke = poke_en ? $urandom_range(1, exp_q.size() - 2) : -1;
    bus.address  = a;
    bus.rw       = rw;
    bus.idata    = wd;
    bus.ack_addr = 1'b0;
    bus.start    = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (bus.i2c_scl && !prev) r++;
      prev = bus.i2c_scl;
      check("wave", {bus.i2c_scl, bus.i2c_sda, bus.hold}, exp_q[i]);
      bus.start    = (i == poke);
      bus.address  = 7'($urandom);
      bus.rw       = 1'($urandom);
      bus.idata    = 8'($urandom);
      bus.ack_addr = (r >= 9 + ack_d);
      bus.sda_in   = (r >= base && r < base + 8) ? rd[7 - (r - base)] : 1'($urandom);
    end
    if (rw && ack_d < MAXW) m_odata = rd;
    m_nack = !(ack_d < MAXW);
    check("odata", bus.odata, m_odata);
`ifdef I2C_MASTER_NACK_FLAG_EN
    check("nack", bus.nack, m_nack);
`endif
  endtask

  task automatic abort_mid();
    int k = $urandom_range(1, 15 * H - 1);
    bus.address = 7'($urandom);
    bus.rw      = 1'($urandom);
    bus.idata   = 8'($urandom);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (k) @(negedge clk);
    check("busy_before_reset", bus.hold, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_odata = 8'h00;
    m_nack  = 1'b0;
    check("abort_scl", bus.i2c_scl, 1'b1);
    check("abort_sda", bus.i2c_sda, 1'b1);
    check("abort_hold", bus.hold, 1'b0);
    check("abort_odata", bus.odata, m_odata);
`ifdef I2C_MASTER_NACK_FLAG_EN
    check("abort_nack", bus.nack, m_nack);
`endif
    @(negedge clk);
  endtask

  function automatic int pick_ack();
    int sel = $urandom_range(0, 5);
    return sel < 3 ? sel : (sel == 3 ? MAXW - 1 : MAXW + sel - 4);
  endfunction

  initial begin
    bus.start    = 1'b0;
    bus.address  = '0;
    bus.rw       = 1'b0;
    bus.idata    = '0;
    bus.ack_addr = 1'b0;
    bus.sda_in   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sda", bus.i2c_sda, 1'b1);
    check("rst_scl", bus.i2c_scl, 1'b1);
    check("rst_hold", bus.hold, 1'b0);
    check("rst_odata", bus.odata, 8'h00);
`ifdef I2C_MASTER_NACK_FLAG_EN
    check("rst_nack", bus.nack, 1'b0);
`endif
    reset = 1'b0;
    @(negedge clk);
    xfer(7'h55, 1'b0, 8'h55, 8'h00, 0, 1'b0);
    xfer(7'h55, 1'b1, 8'h00, 8'hAA, 0, 1'b0);
    xfer(7'h2A, 1'b0, 8'hC3, 8'h00, MAXW, 1'b0);
    xfer(7'h11, 1'b1, 8'h00, 8'h5A, MAXW + 1, 1'b1);
    xfer(7'h6C, 1'b1, 8'h00, 8'h3C, MAXW - 1, 1'b1);
    xfer(7'h7F, 1'b0, 8'h80, 8'h00, 1, 1'b1);
    abort_mid();
    for (int n = 0; n < 30; n++)
      xfer(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), pick_ack(), 1'($urandom));
    abort_mid();
    xfer(7'h01, 1'b1, 8'h00, 8'hFF, 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
